// File: rtl/sid_pkg.sv
// sid_pkg: shared constants and types for the SID voice scheduler.
// Contents: register offsets within a voice's 4-byte window, the
// status-clear address, ctrl bit positions and the FSM state type.
package sid_pkg;

  localparam logic [1:0] FREQ_LO    = 2'd0;
  localparam logic [1:0] FREQ_HI    = 2'd1;
  localparam logic [1:0] CTRL       = 2'd2;
  localparam logic [3:0] STATUS_CLR = 4'd15;

  localparam int CTRL_SYNC = 1;
  localparam int CTRL_TEST = 3;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/sid_voice_sched_if.sv
// sid_voice_sched_if: register-write bus, sample strobe and status/phase
// outputs of the voice scheduler.
//   tick       : one-cycle sample strobe
//   wr_en      : register write strobe (no backpressure)
//   wr_addr    : voice*4 + offset; 15 clears the overrun flag
//   wr_data    : write data byte
//   phase_out  : packed per-voice accumulators, voice v at [v*ACC_W +: ACC_W]
//   busy       : frame update in progress
//   frame_done : one-cycle pulse after the last voice of a frame
//   overrun    : sticky, a tick was dropped because a frame was running
// Modports: master drives tick/writes, slave is the scheduler.
interface sid_voice_sched_if #(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 24
);

  logic                          tick;
  logic                          wr_en;
  logic [3:0]                    wr_addr;
  logic [7:0]                    wr_data;
  logic [ACC_W*NUM_VOICES-1:0]   phase_out;
  logic                          busy;
  logic                          frame_done;
  logic                          overrun;

  modport master (
    output tick, wr_en, wr_addr, wr_data,
    input  phase_out, busy, frame_done, overrun
  );

  modport slave (
    input  tick, wr_en, wr_addr, wr_data,
    output phase_out, busy, frame_done, overrun
  );

endinterface

// File: rtl/sid_phase_step.sv
// sid_phase_step: combinational single-voice phase step.
// Ports:
//   acc_in   : current accumulator value
//   freq     : 16-bit frequency word, zero-extended before the add
//   test     : forces the accumulator to zero (highest priority)
//   sync_hit : hard-sync reset of the accumulator
//   acc_out  : next accumulator value, wraps silently modulo 2^ACC_W
//   msb_rise : top bit moved from 0 to 1 in this step
module sid_phase_step #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [15:0]      freq,
  input  logic             test,
  input  logic             sync_hit,
  output logic [ACC_W-1:0] acc_out,
  output logic             msb_rise
);

  // TEST beats sync, sync beats the normal add; a forced zero can never
  // produce a rising top bit.
  always_comb begin
    acc_out = acc_in + ACC_W'(freq);
    if (test) begin
      acc_out = '0;
    end else if (sync_hit) begin
      acc_out = '0;
    end
    msb_rise = ~acc_in[ACC_W-1] & acc_out[ACC_W-1];
  end

endmodule

// File: rtl/sid_voice_sched.sv
// sid_voice_sched: time-multiplexed phase-accumulator scheduler for the SID
// voices. One shared sid_phase_step is stepped once per voice, in voice
// order, for every accepted tick.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : sid_voice_sched_if.slave (tick, register writes, phase/status out)
// Build option: define SID_HARD_SYNC_EN to build hard sync and the per-voice
// msb_rise flags; without it SYNC bits are stored but have no effect.
module sid_voice_sched
  import sid_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 24
) (
  input logic              clk,
  input logic              rst,
  sid_voice_sched_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VOICES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       upd;
  logic       last_upd;

  logic [NUM_VOICES-1:0][ACC_W-1:0] acc_q;
  logic [NUM_VOICES-1:0][15:0]      freq_q;
  logic [NUM_VOICES-1:0][7:0]       ctrl_q;

  logic busy_q, last_q, done_q, overrun_q;
  logic ovr_set, ovr_clr;

  logic [1:0] wr_voice, wr_off;
  logic       wr_voice_ok;

  logic [ACC_W-1:0] step_acc;
  logic             step_rise;
  logic             sync_hit;

  assign wr_voice    = bus.wr_addr[3:2];
  assign wr_off      = bus.wr_addr[1:0];
  assign wr_voice_ok = (32'(wr_voice) < NUM_VOICES);

  // Only the SYNC and TEST bits steer the datapath; the rest are storage.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_q;

  // State register for the frame sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: a tick in IDLE starts a frame at voice 0, RUN walks
  // one voice per cycle and drops back to IDLE after the last voice.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    upd      = 1'b0;
    last_upd = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        upd = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_upd = 1'b1;
          state_d  = IDLE;
          idx_d    = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign ovr_set = bus.tick && (state_q == RUN);
  assign ovr_clr = bus.wr_en && (bus.wr_addr == STATUS_CLR);

  sid_phase_step #(.ACC_W(ACC_W)) u_step (
    .acc_in   (acc_q[idx_q]),
    .freq     (freq_q[idx_q]),
    .test     (ctrl_q[idx_q][CTRL_TEST]),
    .sync_hit (sync_hit),
    .acc_out  (step_acc),
    .msb_rise (step_rise)
  );

`ifdef SID_HARD_SYNC_EN
  // Each voice syncs to the previous voice's most recent rise flag; voice 0
  // wraps round to the last voice, whose flag is still from the last tick.
  logic [NUM_VOICES-1:0] rise_q;
  logic [1:0]            src_idx;

  assign src_idx  = (idx_q == 2'd0) ? LAST_IDX : idx_q - 2'd1;
  assign sync_hit = ctrl_q[idx_q][CTRL_SYNC] & rise_q[src_idx];

  // Rise flag of the voice being stepped is overwritten on every update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
    end else if (upd) begin
      rise_q[idx_q] <= step_rise;
    end
  end
`else
  logic unused_step_rise;
  assign sync_hit         = 1'b0;
  assign unused_step_rise = step_rise;
`endif

  // Accumulators and voice registers. The step reads the registers before
  // this edge, so a write landing on a voice's update cycle only counts
  // from the next update onwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      freq_q <= '0;
      ctrl_q <= '0;
    end else begin
      if (upd) begin
        acc_q[idx_q] <= step_acc;
      end
      if (bus.wr_en && wr_voice_ok) begin
        case (wr_off)
          FREQ_LO: freq_q[wr_voice][7:0]  <= bus.wr_data;
          FREQ_HI: freq_q[wr_voice][15:8] <= bus.wr_data;
          CTRL:    ctrl_q[wr_voice]       <= bus.wr_data;
          default: ;
        endcase
      end
    end
  end

  // Status flags. busy and frame_done trail the sequencer so that busy
  // covers the update edges and frame_done follows the last one; a new
  // overrun outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN);
      last_q <= last_upd;
      done_q <= last_q;
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.phase_out  = acc_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sid_voice_sched.sv
// tb_sid_voice_sched: directed bench for sid_voice_sched with a
// cycle-level behavioural model compared on every falling edge, plus
// hand-computed literal checks at key points. Works with or without
// SID_HARD_SYNC_EN.
module tb_sid_voice_sched;

  localparam int N = 3;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sid_voice_sched_if #(.NUM_VOICES(N), .ACC_W(W)) bus ();

  sid_voice_sched #(.NUM_VOICES(N), .ACC_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Inputs as seen by the DUT at the most recent rising edge.
  logic       sTick = 1'b0, sWr = 1'b0, sRst = 1'b1;
  logic [3:0] sAddr = 4'h0;
  logic [7:0] sData = 8'h00;

  always @(posedge clk) begin
    sTick <= bus.tick;
    sWr   <= bus.wr_en;
    sAddr <= bus.wr_addr;
    sData <= bus.wr_data;
    sRst  <= rst;
  end

  // Behavioural model: frames are tracked by the cycle number of the
  // accepted tick; voice v is stepped d = v+1 edges later.
  logic [W-1:0] mAcc [N];
  logic [15:0]  mFreq[N];
  logic [7:0]   mCtrl[N];
  bit           mRise[N];
  bit           mOvr, expBusy, expDone, started;
  int           cyc, frameStart;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int v = 0; v < N; v++) begin
      mAcc[v]  = '0;
      mFreq[v] = '0;
      mCtrl[v] = '0;
      mRise[v] = 1'b0;
    end
    mOvr       = 1'b0;
    expBusy    = 1'b0;
    expDone    = 1'b0;
    started    = 1'b0;
    cyc        = 0;
    frameStart = 0;
  endtask

  task automatic stepVoice(input int v);
    logic [W-1:0] oldAcc;
    logic [W-1:0] newAcc;
    int           src;
    oldAcc = mAcc[v];
    src    = (v + N - 1) % N;
    newAcc = oldAcc + W'(mFreq[v]);
    if (mCtrl[v][3]) newAcc = '0;
`ifdef SID_HARD_SYNC_EN
    else if (mCtrl[v][1] && mRise[src]) newAcc = '0;
`endif
    mRise[v] = !oldAcc[W-1] && newAcc[W-1];
    mAcc[v]  = newAcc;
  endtask

  task automatic modelStep();
    int  d, wv, wo;
    bit  inFrame;
    cyc++;
    d       = cyc - frameStart;
    inFrame = started && (d >= 1) && (d <= N);
    if (inFrame) stepVoice(d - 1);
    if (sTick && inFrame) mOvr = 1'b1;
    else if (sWr && sAddr == 4'd15) mOvr = 1'b0;
    if (sWr) begin
      wv = int'(sAddr[3:2]);
      wo = int'(sAddr[1:0]);
      if (wv < N) begin
        if (wo == 0) mFreq[wv][7:0] = sData;
        else if (wo == 1) mFreq[wv][15:8] = sData;
        else if (wo == 2) mCtrl[wv] = sData;
      end
    end
    expBusy = inFrame;
    expDone = started && (d == N + 1);
    if (sTick && !inFrame) begin
      started    = 1'b1;
      frameStart = cyc;
    end
  endtask

  // Compare process: advance the model for the edge just past, then check.
  always @(negedge clk) begin
    logic [N*W-1:0] expPh;
    if (rst || sRst) modelReset();
    else modelStep();
    for (int v = 0; v < N; v++) expPh[v*W +: W] = mAcc[v];
    checkOutput("cyc_phase", bus.phase_out, expPh);
    checkOutput("cyc_busy", bus.busy, expBusy);
    checkOutput("cyc_frame_done", bus.frame_done, expDone);
    checkOutput("cyc_overrun", bus.overrun, mOvr);
  end

  function automatic logic [W-1:0] ph(input int v);
    return bus.phase_out[v*W +: W];
  endfunction

  task automatic applyStimulus(input logic t, input logic w,
                               input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #2;
    bus.tick    = t;
    bus.wr_en   = w;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
  endtask

  task automatic runTick();
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    repeat (5) idle();
  endtask

  // Two ticks 'gap' cycles apart; counts frame_done pulses seen.
  task automatic tickPair(input int gap, output int dones);
    dones = 0;
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    if (bus.frame_done) dones++;
    for (int i = 1; i < gap; i++) begin
      idle();
      if (bus.frame_done) dones++;
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    if (bus.frame_done) dones++;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (bus.frame_done) dones++;
    end
  endtask

  initial begin
    int dones;
    bus.tick    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 4'h0;
    bus.wr_data = 8'h00;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_phase", bus.phase_out, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.frame_done, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    rst = 1'b0;

    // Basic accumulate on voice 0.
    writeReg(4'd0, 8'h00);
    writeReg(4'd1, 8'h10);
    runTick();
    checkOutput("basic_v0", ph(0), 24'h001000);
    checkOutput("basic_v1", ph(1), 24'h000000);
    checkOutput("basic_v2", ph(2), 24'h000000);
    checkOutput("basic_done", bus.frame_done, 1);
    checkOutput("basic_busy", bus.busy, 0);

    // Wrap-around on voice 1.
    writeReg(4'd4, 8'hFF);
    writeReg(4'd5, 8'hFF);
    repeat (256) runTick();
    checkOutput("wrap_pre", ph(1), 24'hFFFF00);
    writeReg(4'd4, 8'hF0);
    writeReg(4'd5, 8'h00);
    runTick();
    checkOutput("wrap_load", ph(1), 24'hFFFFF0);
    writeReg(4'd4, 8'hFF);
    writeReg(4'd5, 8'hFF);
    runTick();
    checkOutput("wrap_v1", ph(1), 24'h00FFEF);
    checkOutput("wrap_v0", ph(0), 24'h103000);
    checkOutput("wrap_no_overrun", bus.overrun, 0);

    // TEST holds voice 2 at zero.
    writeReg(4'd8, 8'h00);
    writeReg(4'd9, 8'h01);
    writeReg(4'd10, 8'h08);
    repeat (5) runTick();
    checkOutput("test_hold", ph(2), 24'h000000);
    writeReg(4'd10, 8'h00);
    runTick();
    checkOutput("test_release", ph(2), 24'h000100);

    // Write landing on voice 2's own update edge uses the old freq.
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    idle();
    idle();
    writeReg(4'd8, 8'h55);
    repeat (3) idle();
    checkOutput("collide_old", ph(2), 24'h000200);
    runTick();
    checkOutput("collide_new", ph(2), 24'h000355);

    // Unused ctrl bits and ignored addresses have no effect.
    writeReg(4'd10, 8'hF5);
    runTick();
    checkOutput("ctrl_other_bits", ph(2), 24'h0004AA);
    writeReg(4'd11, 8'hFF);
    writeReg(4'd13, 8'hFF);
    runTick();
    checkOutput("ignored_addr", ph(2), 24'h0005FF);

    // Overrun and tick spacing.
    tickPair(2, dones);
    checkOutput("ovr_gap2_flag", bus.overrun, 1);
    checkOutput("ovr_gap2_dones", dones, 1);
    writeReg(4'd15, 8'h00);
    idle();
    checkOutput("ovr_clear", bus.overrun, 0);
    tickPair(3, dones);
    checkOutput("ovr_gap3_flag", bus.overrun, 1);
    checkOutput("ovr_gap3_dones", dones, 1);
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b1, 4'd15, 8'h00);
    repeat (5) idle();
    checkOutput("ovr_set_wins", bus.overrun, 1);
    writeReg(4'd15, 8'h00);
    idle();
    checkOutput("ovr_clear2", bus.overrun, 0);
    tickPair(4, dones);
    checkOutput("gap4_flag", bus.overrun, 0);
    checkOutput("gap4_dones", dones, 2);
    tickPair(5, dones);
    checkOutput("gap5_flag", bus.overrun, 0);
    checkOutput("gap5_dones", dones, 2);

    // Reset in the middle of a frame.
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
    idle();
    idle();
    idle();
    rst = 1'b1;
    dones = 0;
    repeat (2) begin
      @(posedge clk);
      #2;
      if (bus.frame_done) dones++;
    end
    checkOutput("midrst_phase", bus.phase_out, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_dones", dones, 0);
    rst = 1'b0;

    // Hard sync from a fresh state.
    writeReg(4'd0, 8'h00);
    writeReg(4'd1, 8'h80);
    writeReg(4'd4, 8'h10);
    writeReg(4'd5, 8'h00);
    writeReg(4'd6, 8'h02);
    runTick();
    checkOutput("sync_t1_v0", ph(0), 24'h008000);
    checkOutput("sync_t1_v1", ph(1), 24'h000010);
    repeat (254) runTick();
    checkOutput("sync_t255_v0", ph(0), 24'h7F8000);
    checkOutput("sync_t255_v1", ph(1), 24'h000FF0);
    runTick();
    checkOutput("sync_t256_v0", ph(0), 24'h800000);
    checkOutput("sync_t256_v2", ph(2), 24'h000000);
`ifdef SID_HARD_SYNC_EN
    checkOutput("sync_t256_v1", ph(1), 24'h000000);
`else
    checkOutput("sync_t256_v1", ph(1), 24'h001000);
`endif
    runTick();
    checkOutput("sync_t257_v0", ph(0), 24'h808000);
`ifdef SID_HARD_SYNC_EN
    checkOutput("sync_t257_v1", ph(1), 24'h000010);
`else
    checkOutput("sync_t257_v1", ph(1), 24'h001010);
`endif

    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
